// File: rtl/sevenseg_capture.sv
// rtl/sevenseg_capture.sv - rebuilds a 32-bit hex word from a scanned seven-segment bus
// Each digit is debounced by a stability counter before it is written into the shadow word.
module sevenseg_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  segments,
  input  logic [7:0]  anodes,
  input  logic        clear,
  output logic [31:0] hex_out,
  output logic [7:0]  digit_mask,
  output logic        frame_valid,
  output logic        error
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

  logic [14:0]   din;
  logic [14:0]   smp;
  logic [CW-1:0] cnt;
  logic          acc;
  logic [31:0]   shadow;

  logic          same;
  logic [7:0]    sel;
  logic          one_hot;
  logic          glyph_ok;
  logic [3:0]    nib;
  logic [31:0]   shadow_new;
  logic [7:0]    mask_new;

  assign din  = {anodes, segments};
  assign same = (din == smp);

  always_comb begin
    glyph_ok = 1'b1;
    nib      = 4'h0;
    case (smp[6:0])
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h10: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      default: glyph_ok = 1'b0;
    endcase
  end

  // sel is the set of selected digits; a single bit set means a legal scan position
  always_comb begin
    sel        = ~smp[14:7];
    one_hot    = (sel != 8'h00) && ((sel & (sel - 8'd1)) == 8'h00);
    shadow_new = shadow;
    for (int i = 0; i < 8; i++) begin
      if (sel[i]) shadow_new[4*i +: 4] = nib;
    end
    mask_new   = digit_mask | sel;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      smp         <= '1;
      cnt         <= '0;
      acc         <= 1'b0;
      shadow      <= '0;
      hex_out     <= '0;
      digit_mask  <= '0;
      frame_valid <= 1'b0;
      error       <= 1'b0;
    end else begin
      smp         <= din;
      frame_valid <= 1'b0;
      if (!same)
        cnt <= CW'(1);
      else if (cnt < CMAX)
        cnt <= cnt + 1'b1;
      // fires only on the transition into saturation, so a held pattern accepts once
      acc <= same && (cnt == CMAX - 1'b1);

      if (clear) begin
        error      <= 1'b0;
        digit_mask <= '0;
        shadow     <= '0;
      end else if (acc && sel != 8'h00) begin
        if (!one_hot || !glyph_ok) begin
          error <= 1'b1;
        end else begin
          shadow <= shadow_new;
          if (mask_new == 8'hFF) begin
            hex_out     <= shadow_new;
            frame_valid <= 1'b1;
            digit_mask  <= '0;
          end else begin
            digit_mask <= mask_new;
          end
        end
      end
    end
  end

endmodule

// File: doc/sevenseg_capture.md
# sevenseg_capture

Receiving end of the 8-digit multiplexed seven-segment interface: it watches the scanned `segments`/`anodes` bus and rebuilds the 32-bit hexadecimal value being displayed. Each digit must be stable for a configurable number of cycles before it is accepted, which debounces the scan. A full 32-bit word is published once all eight digits have been captured. The block is used for display loopback checking and for board-to-board links that carry a value over a seven-segment harness.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a digit is accepted. Legal range is ≥ 2.
- `clock` input, 1 bit: the only clock. All logic is on the rising edge.
- `reset` input, 1 bit: synchronous, active-low reset.
- `segments` input, 7 bits: active-low segments. Bit 0 is segment a, through bit 6 as segment g.
- `anodes` input, 8 bits: active-low digit selects. `anodes[i]=0` selects digit i, which carries hex bits [4i+3:4i].
- `clear` input, 1 bit: synchronous. Clears `error`, `digit_mask` and the shadow word.
- `hex_out` output, 32 bits: the last completely captured word.
- `digit_mask` output, 8 bits: digits captured so far in the current frame.
- `frame_valid` output, 1 bit: one-cycle pulse when `hex_out` is updated.
- `error` output, 1 bit: sticky. Set by an illegal glyph or an illegal anode pattern.

## Operation
**Input sampling**
- `{anodes, segments}` is registered into a sample register every cycle.
- A saturating stability counter tracks the sample:
  - It resets to 1 whenever the new sample differs from the previous one.
  - Otherwise it increments, saturating at `STABLE_CYCLES`.
- An **accept event** fires on the single cycle in which the counter reaches `STABLE_CYCLES`. A held pattern therefore produces exactly one accept.

**On an accept event**
- `anodes` = 8'hFF (blank): no action.
- Exactly one anode bit low, and the segments match a glyph:
  - Write the nibble into shadow slot i.
  - Set `digit_mask[i]`.
  - If the digit is already captured, overwrite it without flagging an error.
- Exactly one anode bit low, and the segments match no glyph:
  - Set `error`.
  - Leave the mask and shadow unchanged.
- Two or more anode bits low: set `error`, no capture.

**Glyph table (active-low, hex value of `segments`)**
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
- 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Every other pattern is illegal.

**Frame completion**
- When an accept would make the mask 8'hFF, the following happen at the same edge:
  - `hex_out` ← shadow word, including the new nibble.
  - `frame_valid` = 1 for one cycle.
  - `digit_mask` ← 0. The mask never reads 8'hFF.
- The shadow word is retained and is overwritten by the next frame.

**Priority**
- `clear` beats an accept in the same cycle: that accept is discarded.
- `clear` does not affect `hex_out`, the sample register or the counter.
- `error` stays set until `clear` or `reset`.

## Timing
**Reset values**
- `hex_out` = 0, `digit_mask` = 0, `frame_valid` = 0, `error` = 0.
- Sample register = all ones (blank). Stability counter = 0.

**Latency**
- Input pattern constant from edge t (sampled at t, counter = 1).
- Accept is registered at edge t+`STABLE_CYCLES`.
- `digit_mask`, `error`, `hex_out` and `frame_valid` are visible after that edge.

**Glitch rejection**
- Any pattern lasting fewer than `STABLE_CYCLES` samples is ignored.

**Reset mid-frame**
- All partial capture is discarded.
- The next frame must deliver all eight digits again.

**Scan rate**
- The source must hold each digit for at least `STABLE_CYCLES`+1 cycles.
- Slower scans are fine. Faster scans capture nothing and raise no error.

**Counter width**
- `$clog2(STABLE_CYCLES+1)`.

## Test plan
- **Full scan.** `STABLE_CYCLES`=4. Scan digits 0..7 with the glyphs for 32'h89ABCDEF, 6 cycles per digit. Expect:
  - `frame_valid` to pulse once, 4 cycles after the digit 7 pattern appears.
  - `hex_out` = 32'h89ABCDEF.
  - `digit_mask` to return to 0.
- **Glitch.** Insert a 2-cycle `anodes`=8'hFD/`segments`=7'h24 glitch between valid digits. Expect digit 1 not captured and `error` = 0.
- **Illegal glyph.** Hold digit 3 with `segments`=7'h7F for 6 cycles. Expect `error` = 1, `digit_mask[3]` = 0, and `error` to stay 1 through a later full valid frame, until `clear`.
- **Multi-anode.** Hold `anodes`=8'hFC with `segments`=7'h40 for 6 cycles. Expect `error` = 1 and no mask change.
- **Reset and clear.**
  - After 5 digits are captured, pulse `reset` low for 1 cycle: expect all outputs 0, and a fresh full scan of 32'h00000001 gives `hex_out` = 32'h00000001.
  - Assert `clear` on an accept edge: expect the mask bit not set.
- **Hold and overwrite.**
  - Hold one digit for 40 cycles: expect exactly one accept.
  - Re-scan digit 2 with a different glyph before the frame completes: expect the final `hex_out` to carry the latest nibble.
